ab_bank_ctrl: RTL and testbench
===============================

# ab_bank_ctrl

Round-robin controller that shares one WIDTH-bit bank of AB flip-flop cells among NREQ requesters. Each request carries a 2-bit AB command ({B,A}: 00 hold, 01 clear, 10 set, 11 toggle) and a bit index. The controller grants one request at a time, applies the command to the addressed cell, and acknowledges with a one-cycle grant pulse. It also publishes the bank contents and their XOR parity, giving the chip-level glue a single serialized write path into the AB register bank.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of AB cells in the bank (2..16)
- IDXW, 3, index width; must satisfy 2^IDXW >= WIDTH
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester; level, held until granted
- op  in  2*NREQ  command of requester i at op[2i+1:2i], encoded {B,A}
- idx  in  IDXW*NREQ  target bit of requester i at idx[IDXW*i+IDXW-1:IDXW*i]
- gnt  out  NREQ  one-hot, one-cycle completion pulse
- err  out  1  pulses with gnt when the latched index is >= WIDTH
- busy  out  1  high whenever state != IDLE
- Q  out  WIDTH  bank contents
- Z  out  1  XOR reduction of Q

## Operation
- FSM with three states: IDLE, EXEC, DONE.
- IDLE:
  - If req == 0, remain in IDLE.
  - Otherwise pick winner w as the first asserted req scanning upward from ptr, wrapping around.
  - Latch w, op[w] and idx[w], then go to EXEC.
- EXEC:
  - If the latched idx < WIDTH, update Q[idx]: 00 hold, 01 clear to 0, 10 set to 1, 11 invert.
  - If the latched idx >= WIDTH, leave Q unchanged and assert err.
  - Assert gnt[w] and go to DONE.
- DONE:
  - Clear gnt and err.
  - Set ptr to (w+1) mod NREQ.
  - Go to IDLE.
- Changes on req, op or idx during EXEC and DONE are ignored; the values are already latched.
- Op 00 is still a full transaction and is granted normally.
- Requester protocol:
  - A requester keeps req, op and idx stable until it sees gnt.
  - It drops req at the edge that ends the gnt cycle.
  - If req is still high in the following IDLE cycle, it counts as a new request.
- A requester may withdraw req while the controller is in IDLE; nothing is latched and nothing is granted.
- Z is combinational from Q and always equals ^Q.

## Timing
- Reset values: Q=0, gnt=0, err=0, busy=0, ptr=0, state=IDLE; therefore Z=0.
- Reset is checked ahead of every other condition. A reset during EXEC or DONE aborts the transaction: no gnt, and Q is cleared.
- Latency and throughput, taking edge t as the one that samples req in IDLE:
  - Q update and gnt become visible after edge t+1.
  - gnt drops and busy falls after edge t+2.
  - One transaction every 3 cycles; the next request can be sampled at edge t+3.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ transactions.
- All outputs except Z are registered.

## Structure
- Shared header ab_defs.vh holds:
  - Op encodings: AB_HOLD=2'b00, AB_CLR=2'b01, AB_SET=2'b10, AB_TGL=2'b11.
  - State encodings: S_IDLE, S_EXEC, S_DONE.
- Sub-module ab_rr_pick: combinational round-robin selector.
  - Inputs: req, ptr.
  - Outputs: one-hot winner and its binary index; valid = |req.
- The AB update is a case statement inside ab_bank_ctrl on the latched op. The bank is not built from separate cell instances, because the bank needs a reset.

## Test plan
- Reset, then a single command: req=0001, op0=10, idx0=5. Required: gnt=0001 one cycle after the sampling edge, Q=8'h20, Z=1, busy high for 2 cycles.
- Toggle pair: requester 2 issues op=11 on idx 0, twice. Required: Q=8'h01 after the first transaction and 8'h00 after the second; Z follows 1 then 0.
- Fairness: req=1111 held, each requester re-requesting immediately after its grant. Required: grants 0001, 0010, 0100, 1000, 0001, each 3 cycles apart.
- Simultaneous requests with ptr=2 and req=0011. Required: requester 0 wins, then requester 1.
- Bad index: idx=6 with WIDTH=6 and op=10. Required: gnt and err pulse together, Q unchanged.
- Reset in EXEC after a set command has been latched. Required: no gnt, Q=0, state IDLE on the next cycle.

Source files
------------

// File: rtl/ab_bank_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ab_bank_ctrl_pkg
// Description : Shared definitions for the AB bank controller. It holds the
//               AB command encodings ({B,A}) and the controller state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ab_bank_ctrl_pkg;

    // AB cell commands, encoded {B,A}
    localparam logic [1:0] AB_HOLD = 2'b00;
    localparam logic [1:0] AB_CLR  = 2'b01;
    localparam logic [1:0] AB_SET  = 2'b10;
    localparam logic [1:0] AB_TGL  = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } ab_state_t;

endpackage : ab_bank_ctrl_pkg
`default_nettype wire

// File: rtl/ab_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ab_rr_pick
// Description : Combinational round-robin selector. It returns the first
//               asserted request found by scanning upward from ptr, wrapping
//               past NREQ-1 back to 0.
// Ports       : req     - request vector
//               ptr     - highest-priority requester index
//               win_oh  - one-hot winner (all zero when no request)
//               win_idx - binary index of the winner
//               valid   - at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module ab_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx,
    output logic            valid
);

    logic w_found;

    // First pass covers ptr..NREQ-1. The second pass covers the wrapped
    // range 0..ptr-1, so lower indices only win when nothing at or above
    // ptr is requesting.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (i >= int'(ptr))) begin
                w_found    = 1'b1;
                win_oh[i]  = 1'b1;
                win_idx    = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (i < int'(ptr))) begin
                w_found    = 1'b1;
                win_oh[i]  = 1'b1;
                win_idx    = PW'(i);
            end
        end
    end

    assign valid = |req;

endmodule : ab_rr_pick
`default_nettype wire

// File: rtl/ab_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ab_bank_ctrl
// Description : Round-robin controller that serializes NREQ requesters onto
//               a single WIDTH-bit bank of AB flip-flop cells. Each granted
//               request applies a hold, clear, set or toggle command to one
//               cell and is acknowledged by a one-cycle gnt pulse.
// Ports       : clk   - rising-edge clock
//               reset - synchronous active-high reset
//               req   - per-requester level request
//               op    - per-requester {B,A} command, 2 bits each
//               idx   - per-requester target cell index, IDXW bits each
//               gnt   - one-hot completion pulse
//               err   - pulses with gnt when the latched index is >= WIDTH
//               busy  - high whenever the controller is not idle
//               Q     - bank contents
//               Z     - XOR parity of Q (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module ab_bank_ctrl
    import ab_bank_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      op,
    input  logic [IDXW*NREQ-1:0]   idx,
    output logic [NREQ-1:0]        gnt,
    output logic                   err,
    output logic                   busy,
    output logic [WIDTH-1:0]       Q,
    output logic                   Z
);

    localparam int PW = $clog2(NREQ);

    ab_state_t          r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_win;
    logic [NREQ-1:0]    r_win_oh;
    logic [1:0]         r_op;
    logic [IDXW-1:0]    r_idx;

    logic [NREQ-1:0]    w_pick_oh;
    logic [PW-1:0]      w_pick_idx;
    logic               w_pick_valid;
    logic [1:0]         w_op_sel;
    logic [IDXW-1:0]    w_idx_sel;
    logic               w_in_range;
    logic [WIDTH-1:0]   w_q_next;

    ab_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .win_oh  (w_pick_oh),
        .win_idx (w_pick_idx),
        .valid   (w_pick_valid)
    );

    // Route the winner's command and index with a one-hot mux.
    always_comb begin
        w_op_sel  = AB_HOLD;
        w_idx_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_oh[i]) begin
                w_op_sel  = op[2*i +: 2];
                w_idx_sel = idx[IDXW*i +: IDXW];
            end
        end
    end

    assign w_in_range = (int'(r_idx) < WIDTH);

    // Next bank value for the latched command. An out-of-range index
    // matches no cell, so the bank passes through unchanged.
    always_comb begin
        w_q_next = Q;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(r_idx) == i) begin
                case (r_op)
                    AB_CLR:  w_q_next[i] = 1'b0;
                    AB_SET:  w_q_next[i] = 1'b1;
                    AB_TGL:  w_q_next[i] = ~Q[i];
                    default: w_q_next[i] = Q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_win_oh <= '0;
            r_op     <= AB_HOLD;
            r_idx    <= '0;
            gnt      <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            Q        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_win    <= w_pick_idx;
                        r_win_oh <= w_pick_oh;
                        r_op     <= w_op_sel;
                        r_idx    <= w_idx_sel;
                        busy     <= 1'b1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_in_range) begin
                        Q <= w_q_next;
                    end
                    err     <= ~w_in_range;
                    gnt     <= r_win_oh;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    gnt  <= '0;
                    err  <= 1'b0;
                    busy <= 1'b0;
                    // NREQ need not be a power of two, so wrap explicitly.
                    if (int'(r_win) == NREQ - 1) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_win + 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    gnt     <= '0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Z = ^Q;

endmodule : ab_bank_ctrl
`default_nettype wire

// File: tb/tb_ab_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ab_bank_ctrl
// Description : Self-checking bench for ab_bank_ctrl. Directed transactions
//               push hand-computed grant, err, Q and Z values into a queue.
//               A monitor pops and compares an entry each time gnt is seen.
//               The bank is 6 cells wide so that indices 6 and 7 are out of
//               range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ab_bank_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 6;
    localparam int IDXW  = 3;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req   = '0;
    logic [2*NREQ-1:0]     op    = '0;
    logic [IDXW*NREQ-1:0]  idx   = '0;
    logic [NREQ-1:0]       gnt;
    logic                  err;
    logic                  busy;
    logic [WIDTH-1:0]      Q;
    logic                  Z;

    typedef struct {
        logic [NREQ-1:0]  g;
        logic             e;
        logic [WIDTH-1:0] q;
        logic             z;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   gnt_cyc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    ab_bank_ctrl #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .op    (op),
        .idx   (idx),
        .gnt   (gnt),
        .err   (err),
        .busy  (busy),
        .Q     (Q),
        .Z     (Z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic e,
                        input logic [WIDTH-1:0] q, input logic z);
        exp_t t;
        t.g = g; t.e = e; t.q = q; t.z = z;
        exp_q.push_back(t);
    endtask

    task automatic set_req(input int r, input logic [1:0] o, input logic [IDXW-1:0] ix);
        op[2*r +: 2]        = o;
        idx[IDXW*r +: IDXW] = ix;
        req[r]              = 1'b1;
    endtask

    // Serve until ngr grants have been seen. With rereq set, requesters stay
    // asserted across their grants; the last grant drops everything.
    task automatic serve(input int ngr, input bit rereq);
        int got;
        got = 0;
        for (int c = 0; c < 200 && got < ngr; c++) begin
            @(posedge clk); #1;
            if (gnt != '0) begin
                got++;
                if (got == ngr) req = '0;
                else if (!rereq) req = req & ~gnt;
            end
        end
        if (got < ngr) chk("serve_timeout", got, ngr);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (gnt != '0) begin
            gnt_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("gnt", 32'(gnt), 32'(mon_e.g));
                chk("err", 32'(err), 32'(mon_e.e));
                chk("Q",   32'(Q),   32'(mon_e.q));
                chk("Z",   32'(Z),   32'(mon_e.z));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_Q",    32'(Q),    32'd0);
        chk("rst_Z",    32'(Z),    32'd0);
        chk("rst_gnt",  32'(gnt),  32'd0);
        chk("rst_err",  32'(err),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single set on bit 5, with latency and busy length checked
        set_req(0, 2'b10, 3'd5);
        push(4'b0001, 1'b0, 6'h20, 1'b1);
        @(posedge clk); #1;
        chk("t0_busy", 32'(busy), 32'd1);
        chk("t0_gnt",  32'(gnt),  32'd0);
        @(posedge clk); #1;
        chk("t1_gnt",  32'(gnt),  32'b0001);
        chk("t1_busy", 32'(busy), 32'd1);
        req = '0;
        @(posedge clk); #1;
        chk("t2_gnt",  32'(gnt),  32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Requester 2 toggles bit 0 twice
        do_reset();
        set_req(2, 2'b11, 3'd0);
        push(4'b0100, 1'b0, 6'h01, 1'b1);
        serve(1, 1'b0);
        set_req(2, 2'b11, 3'd0);
        push(4'b0100, 1'b0, 6'h00, 1'b0);
        serve(1, 1'b0);

        // Fairness: all four requesters held; requester i sets bit i
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b10, 3'(i));
        push(4'b0001, 1'b0, 6'h01, 1'b1);
        push(4'b0010, 1'b0, 6'h03, 1'b0);
        push(4'b0100, 1'b0, 6'h07, 1'b1);
        push(4'b1000, 1'b0, 6'h0F, 1'b0);
        push(4'b0001, 1'b0, 6'h0F, 1'b0);
        gnt_cyc.delete();
        serve(5, 1'b1);
        chk("fair_count", gnt_cyc.size(), 32'd5);
        for (int i = 1; i < gnt_cyc.size(); i++)
            chk("fair_spacing", gnt_cyc[i] - gnt_cyc[i-1], 32'd3);

        // ptr=2 with requesters 0 and 1 asserted together: 0 wins, then 1
        do_reset();
        set_req(1, 2'b10, 3'd1);
        push(4'b0010, 1'b0, 6'h02, 1'b1);
        serve(1, 1'b0);
        set_req(0, 2'b10, 3'd2);
        set_req(1, 2'b11, 3'd1);
        push(4'b0001, 1'b0, 6'h06, 1'b0);
        push(4'b0010, 1'b0, 6'h04, 1'b1);
        serve(2, 1'b0);

        // Out-of-range indices leave Q alone and raise err
        do_reset();
        set_req(3, 2'b10, 3'd4);
        push(4'b1000, 1'b0, 6'h10, 1'b1);
        serve(1, 1'b0);
        set_req(3, 2'b10, 3'd6);
        push(4'b1000, 1'b1, 6'h10, 1'b1);
        serve(1, 1'b0);
        set_req(3, 2'b11, 3'd7);
        push(4'b1000, 1'b1, 6'h10, 1'b1);
        serve(1, 1'b0);
        chk("post_err_clear", 32'(err), 32'd0);

        // Reset while in EXEC aborts the transaction
        set_req(0, 2'b10, 3'd0);
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        req   = '0;
        @(posedge clk); #1;
        chk("abort_gnt",  32'(gnt),  32'd0);
        chk("abort_Q",    32'(Q),    32'd0);
        chk("abort_busy0", 32'(busy), 32'd0);
        chk("abort_err",  32'(err),  32'd0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_Q",    32'(Q),    32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ab_bank_ctrl
`default_nettype wire
